// File: rtl/game_pkg.sv
// Shared types, sizes and helpers for the Pacman game-state controller.
package game_pkg;

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    PLAY    = 2'd1,
    RESPAWN = 2'd2,
    OVER    = 2'd3
  } game_state_t;

  localparam int NUM_GHOSTS = 3;
  localparam int NUM_FRUIT  = 3;
  localparam int DIST_W     = 20;
  localparam int SCORE_W    = 16;
  localparam int LIVES_W    = 2;

  localparam int GHOST_PTS_DEF = 50;
  localparam int FRUIT_PTS_DEF = 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold 0 .. max(a, b) - 1, never narrower than one bit.
  function automatic int timer_width(input int a, input int b);
    int w;
    w = $clog2(max_int(a, b));
    return (w < 1) ? 1 : w;
  endfunction

  // Score accumulation that sticks at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] base,
                                                 input logic [SCORE_W:0]   inc);
    logic [SCORE_W:0] sum;
    sum = {1'b0, base} + inc;
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Bundle between the distance datapath and the game-state controller.
interface game_ctrl_if;
  import game_pkg::*;

  // Datapath -> controller
  logic                                  hasMoved;
  logic [NUM_GHOSTS-1:0][DIST_W-1:0]     ghost_dist;
  logic [NUM_FRUIT-1:0][DIST_W-1:0]      fruit_dist;

  // Controller -> ghost / pacman / color-mapper blocks
  logic [LIVES_W-1:0]                    lives;
  logic                                  reversal;
  logic [NUM_GHOSTS-1:0]                 ghost_en;
  logic [NUM_FRUIT-1:0]                  fruit_on;
  logic                                  isDefeated;
  logic                                  freeze;
  logic                                  death;
  logic [SCORE_W-1:0]                    score;

  modport master (
    output hasMoved, ghost_dist, fruit_dist,
    input  lives, reversal, ghost_en, fruit_on, isDefeated, freeze, death, score
  );

  modport slave (
    input  hasMoved, ghost_dist, fruit_dist,
    output lives, reversal, ghost_en, fruit_on, isDefeated, freeze, death, score
  );

endinterface

// File: rtl/game_ctrl_frame_timer.sv
// Loadable frame up-counter with a terminal-count flag.
// Shared by the power window and the respawn freeze, which never overlap.
module frame_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,    // restart at zero
  input  logic             en,      // advance by one frame
  input  logic [WIDTH-1:0] tc_val,  // last count of the current window
  output logic             tc
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: restart has priority over advance.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == tc_val);

endmodule

// File: rtl/game_ctrl.sv
// Frame-rate game-state controller: lives, power window, ghost/fruit enables,
// respawn freeze, game-over and score, all updated once per frame edge.
module game_ctrl
  import game_pkg::*;
#(
  parameter int HIT_R2         = 64,
  parameter int LIVES_INIT     = 2,
  parameter int POWER_FRAMES   = 600,
  parameter int RESPAWN_FRAMES = 60,
  parameter int GHOST_PTS      = GHOST_PTS_DEF,
  parameter int FRUIT_PTS      = FRUIT_PTS_DEF
) (
  input  logic         frame_clk,
  input  logic         Reset_n,
  game_ctrl_if.slave   bus
);

  localparam int TW = timer_width(POWER_FRAMES, RESPAWN_FRAMES);

  localparam logic [DIST_W-1:0]  HIT_LIM    = DIST_W'(HIT_R2);
  localparam logic [LIVES_W-1:0] LIVES_RST  = LIVES_W'(LIVES_INIT);
  localparam logic [SCORE_W:0]   GHOST_INC  = (SCORE_W + 1)'(GHOST_PTS);
  localparam logic [SCORE_W:0]   FRUIT_INC  = (SCORE_W + 1)'(FRUIT_PTS);
  localparam logic [TW-1:0]      POWER_TC   = TW'(POWER_FRAMES - 1);
  localparam logic [TW-1:0]      RESPAWN_TC = TW'(RESPAWN_FRAMES - 1);

  game_state_t            state_q,       state_d;
  logic [LIVES_W-1:0]     lives_q,       lives_d;
  logic                   reversal_q,    reversal_d;
  logic [NUM_GHOSTS-1:0]  ghost_en_q,    ghost_en_d;
  logic [NUM_FRUIT-1:0]   fruit_on_q,    fruit_on_d;
  logic                   is_defeated_q, is_defeated_d;
  logic                   freeze_q,      freeze_d;
  logic                   death_q,       death_d;
  logic [SCORE_W-1:0]     score_q,       score_d;

  logic [NUM_GHOSTS-1:0]  ghit;
  logic [NUM_FRUIT-1:0]   fhit;
  logic [SCORE_W:0]       pts_inc;
  logic                   fruit_taken;

  logic                   timer_load;
  logic                   timer_en;
  logic                   timer_tc;
  logic [TW-1:0]          timer_tc_val;

  // One counter serves both windows; the state says which length applies.
  assign timer_tc_val = (state_q == RESPAWN) ? RESPAWN_TC : POWER_TC;

  frame_timer #(
    .WIDTH (TW)
  ) u_frame_timer (
    .clk    (frame_clk),
    .rst_n  (Reset_n),
    .load   (timer_load),
    .en     (timer_en),
    .tc_val (timer_tc_val),
    .tc     (timer_tc)
  );

  // Collision terms, masked by what is currently alive / present.
  always_comb begin
    ghit = '0;
    fhit = '0;
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      ghit[i] = (bus.ghost_dist[i] < HIT_LIM) && ghost_en_q[i];
    end
    for (int j = 0; j < NUM_FRUIT; j++) begin
      fhit[j] = (bus.fruit_dist[j] < HIT_LIM) && fruit_on_q[j];
    end
  end

  // Per-frame game rules and state transitions.
  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    reversal_d    = reversal_q;
    ghost_en_d    = ghost_en_q;
    fruit_on_d    = fruit_on_q;
    is_defeated_d = 1'b0;
    freeze_d      = freeze_q;
    death_d       = death_q;
    score_d       = score_q;
    pts_inc       = '0;
    fruit_taken   = 1'b0;
    timer_load    = 1'b0;
    timer_en      = 1'b0;

    unique case (state_q)
      WAIT: begin
        freeze_d = 1'b0;
        if (bus.hasMoved) begin
          state_d = PLAY;
        end
      end

      PLAY: begin
        if (!reversal_q && (|ghit)) begin
          // Pacman caught: the death path wins over any fruit this frame.
          is_defeated_d = 1'b1;
          reversal_d    = 1'b0;
          ghost_en_d    = '1;
          freeze_d      = 1'b1;
          timer_load    = 1'b1;
          if (lives_q == '0) begin
            state_d = OVER;
            death_d = 1'b1;
          end else begin
            lives_d = lives_q - 1'b1;
            state_d = RESPAWN;
          end
        end else begin
          // Ghosts caught during the power window are eaten and each one scores.
          if (reversal_q) begin
            for (int i = 0; i < NUM_GHOSTS; i++) begin
              if (ghit[i]) begin
                ghost_en_d[i] = 1'b0;
                pts_inc       = pts_inc + GHOST_INC;
              end
            end
          end

          // Lowest-index fruit wins; others stay for later frames.
          for (int j = 0; j < NUM_FRUIT; j++) begin
            if (fhit[j] && !fruit_taken) begin
              fruit_on_d[j] = 1'b0;
              pts_inc       = pts_inc + FRUIT_INC;
              fruit_taken   = 1'b1;
            end
          end

          if (fruit_taken) begin
            // A fruit opens the window or restarts it from zero.
            reversal_d = 1'b1;
            timer_load = 1'b1;
          end else if (reversal_q) begin
            if (timer_tc) begin
              reversal_d = 1'b0;
              timer_load = 1'b1;
              ghost_en_d = '1;
            end else begin
              timer_en = 1'b1;
            end
          end

          score_d = sat_add(score_q, pts_inc);
        end
      end

      RESPAWN: begin
        reversal_d = 1'b0;
        if (timer_tc) begin
          state_d    = WAIT;
          freeze_d   = 1'b0;
          timer_load = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
      end

      OVER: begin
        death_d  = 1'b1;
        freeze_d = 1'b1;
      end

      default: begin
        state_d = WAIT;
      end
    endcase
  end

  // Registered game state and outputs.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= WAIT;
      lives_q       <= LIVES_RST;
      reversal_q    <= 1'b0;
      ghost_en_q    <= '1;
      fruit_on_q    <= '1;
      is_defeated_q <= 1'b0;
      freeze_q      <= 1'b0;
      death_q       <= 1'b0;
      score_q       <= '0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      reversal_q    <= reversal_d;
      ghost_en_q    <= ghost_en_d;
      fruit_on_q    <= fruit_on_d;
      is_defeated_q <= is_defeated_d;
      freeze_q      <= freeze_d;
      death_q       <= death_d;
      score_q       <= score_d;
    end
  end

  assign bus.lives      = lives_q;
  assign bus.reversal   = reversal_q;
  assign bus.ghost_en   = ghost_en_q;
  assign bus.fruit_on   = fruit_on_q;
  assign bus.isDefeated = is_defeated_q;
  assign bus.freeze     = freeze_q;
  assign bus.death      = death_q;
  assign bus.score      = score_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: expected outputs are queued with each
// frame's stimulus and popped for comparison after the frame edge.
module tb_game_ctrl;
  import game_pkg::*;

  typedef struct packed {
    logic [1:0]  lives;
    logic        reversal;
    logic [2:0]  ghost_en;
    logic [2:0]  fruit_on;
    logic        is_def;
    logic        freeze;
    logic        death;
    logic [15:0] score;
  } obs_t;

  localparam obs_t RST = '{lives: 2'd2, reversal: 1'b0, ghost_en: 3'b111,
                           fruit_on: 3'b111, is_def: 1'b0, freeze: 1'b0,
                           death: 1'b0, score: 16'd0};
  localparam logic [19:0] FAR = 20'd100000;

  logic frame_clk = 1'b0;
  logic Reset_n   = 1'b0;

  game_ctrl_if bus ();

  game_ctrl #(
    .HIT_R2         (64),
    .LIVES_INIT     (2),
    .POWER_FRAMES   (600),
    .RESPAWN_FRAMES (60),
    .GHOST_PTS      (50),
    .FRUIT_PTS      (10)
  ) dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .bus       (bus.slave)
  );

  always #5 frame_clk = ~frame_clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t sb[$];
  obs_t cur;
  obs_t got;
  obs_t e;

  function automatic obs_t sample();
    obs_t o;
    o.lives    = bus.lives;
    o.reversal = bus.reversal;
    o.ghost_en = bus.ghost_en;
    o.fruit_on = bus.fruit_on;
    o.is_def   = bus.isDefeated;
    o.freeze   = bus.freeze;
    o.death    = bus.death;
    o.score    = bus.score;
    return o;
  endfunction

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic far_all();
    for (int i = 0; i < 3; i++) begin
      bus.ghost_dist[i] = FAR;
      bus.fruit_dist[i] = FAR;
    end
  endtask

  // Async reset, release away from the edge, then step into PLAY.
  task automatic reset_to_play();
    #2;
    Reset_n      = 1'b0;
    bus.hasMoved = 1'b0;
    far_all();
    #7;
    Reset_n = 1'b1;
    cur = RST;
    bus.hasMoved = 1'b1;
    sb.push_back(cur);
    tick();
    got = sample(); e = sb.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL enter_play got=%h exp=%h", got, e); end
  endtask

  task automatic test_reset();
    bus.hasMoved = 1'b0;
    far_all();
    #12;
    got = sample(); n_tests++;
    if (got !== RST) begin n_fail++; $display("FAIL reset_vals got=%h exp=%h", got, RST); end
    Reset_n = 1'b1;
    cur = RST;
    for (int f = 0; f < 10; f++) begin
      sb.push_back(cur);
      tick();
      got = sample(); e = sb.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL wait_idle f%0d got=%h exp=%h", f, got, e); end
    end
    bus.hasMoved = 1'b1;
    sb.push_back(cur);
    tick();
    got = sample(); e = sb.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL wait_to_play got=%h exp=%h", got, e); end
  endtask

  // Three ghost hits with no power: two respawns, then sticky game over.
  task automatic test_ghost_death();
    for (int h = 0; h < 3; h++) begin
      bus.ghost_dist[0] = 20'd10;
      cur.is_def = 1'b1;
      cur.freeze = 1'b1;
      if (cur.lives != 2'd0) cur.lives = cur.lives - 2'd1;
      else                   cur.death = 1'b1;
      sb.push_back(cur);
      tick();
      bus.ghost_dist[0] = FAR;
      got = sample(); e = sb.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL death_hit h%0d got=%h exp=%h", h, got, e); end
      cur.is_def = 1'b0;
      if (cur.death) begin
        bus.ghost_dist[1] = 20'd0;
        for (int f = 0; f < 5; f++) begin
          sb.push_back(cur);
          tick();
          got = sample(); e = sb.pop_front(); n_tests++;
          if (got !== e) begin n_fail++; $display("FAIL over_hold f%0d got=%h exp=%h", f, got, e); end
        end
        bus.ghost_dist[1] = FAR;
      end else begin
        for (int f = 1; f <= 61; f++) begin
          if (f == 60) cur.freeze = 1'b0;
          sb.push_back(cur);
          tick();
          got = sample(); e = sb.pop_front(); n_tests++;
          if (got !== e) begin n_fail++; $display("FAIL respawn h%0d f%0d got=%h exp=%h", h, f, got, e); end
        end
      end
    end
  endtask

  task automatic test_fruit_power();
    reset_to_play();
    bus.fruit_dist[1] = 20'd0;
    cur.fruit_on = 3'b101;
    cur.score    = 16'd10;
    for (int f = 0; f < 604; f++) begin
      cur.reversal = (f <= 599);
      sb.push_back(cur);
      tick();
      got = sample(); e = sb.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL fruit_power f%0d got=%h exp=%h", f, got, e); end
    end
  endtask

  task automatic test_ghost_eat();
    reset_to_play();
    bus.fruit_dist[0] = 20'd0;
    cur.fruit_on = 3'b110;
    for (int f = 0; f < 603; f++) begin
      if (f == 1) bus.fruit_dist[0] = FAR;
      if (f == 6) begin bus.ghost_dist[0] = 20'd5; bus.ghost_dist[2] = 20'd5; end
      if (f == 8) begin bus.ghost_dist[0] = FAR;   bus.ghost_dist[2] = FAR;   end
      cur.reversal = (f <= 599);
      cur.ghost_en = (f >= 6 && f <= 599) ? 3'b010 : 3'b111;
      cur.score    = (f >= 6) ? 16'd110 : 16'd10;
      sb.push_back(cur);
      tick();
      got = sample(); e = sb.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL ghost_eat f%0d got=%h exp=%h", f, got, e); end
    end
  endtask

  task automatic test_retrigger();
    reset_to_play();
    bus.fruit_dist[0] = 20'd0;
    for (int f = 0; f < 904; f++) begin
      if (f == 1)   bus.fruit_dist[0] = FAR;
      if (f == 300) bus.fruit_dist[2] = 20'd0;
      cur.fruit_on = (f < 300) ? 3'b110 : 3'b010;
      cur.score    = (f < 300) ? 16'd10 : 16'd20;
      cur.reversal = (f <= 899);
      sb.push_back(cur);
      tick();
      got = sample(); e = sb.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL retrigger f%0d got=%h exp=%h", f, got, e); end
    end
  endtask

  // dist == HIT_R2 is a miss, HIT_R2-1 a hit; simultaneous fruits drain low index first.
  task automatic test_threshold();
    obs_t plan[5];
    reset_to_play();
    plan[0] = cur;
    plan[1] = cur; plan[1].fruit_on = 3'b110; plan[1].score = 16'd10; plan[1].reversal = 1'b1;
    plan[2] = plan[1]; plan[2].fruit_on = 3'b100; plan[2].score = 16'd20;
    plan[3] = plan[2]; plan[3].fruit_on = 3'b000; plan[3].score = 16'd30;
    plan[4] = plan[3]; plan[4].ghost_en = 3'b101; plan[4].score = 16'd80;
    for (int f = 0; f < 5; f++) begin
      case (f)
        0: begin bus.ghost_dist[1] = 20'd64; bus.fruit_dist[2] = 20'd64; end
        1: begin
             bus.ghost_dist[1] = FAR;
             for (int j = 0; j < 3; j++) bus.fruit_dist[j] = 20'd63;
           end
        4: bus.ghost_dist[1] = 20'd63;
        default: ;
      endcase
      sb.push_back(plan[f]);
      tick();
      got = sample(); e = sb.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL threshold f%0d got=%h exp=%h", f, got, e); end
    end
    far_all();
  endtask

  task automatic test_same_frame_and_reset();
    reset_to_play();
    bus.ghost_dist[1] = 20'd3;
    bus.fruit_dist[0] = 20'd3;
    cur.lives  = 2'd1;
    cur.is_def = 1'b1;
    cur.freeze = 1'b1;
    for (int f = 0; f < 10; f++) begin
      if (f == 1) begin far_all(); cur.is_def = 1'b0; end
      sb.push_back(cur);
      tick();
      got = sample(); e = sb.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL same_frame f%0d got=%h exp=%h", f, got, e); end
    end
    #2;
    Reset_n = 1'b0;
    #1;
    got = sample(); n_tests++;
    if (got !== RST) begin n_fail++; $display("FAIL mid_respawn_reset got=%h exp=%h", got, RST); end
    #6;
    Reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ghost_death();
    test_fruit_power();
    test_ghost_eat();
    test_retrigger();
    test_threshold();
    test_same_frame_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
